// File: rtl/inv_subbytes_seq.sv
`timescale 1ns/1ps
// Inverse SubBytes engine for the AES-128 decrypt round. The 16 state bytes
// pass through NUM_SBOX shared inverse S-boxes over 16/NUM_SBOX cycles.

module inv_sbox (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] b
);
  // Row = x (upper nibble), column = y (lower nibble).
  localparam logic [7:0] TBL [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign b = TBL[{x, y}];
endmodule

// state | meaning
// IDLE  | waiting for a state; in_ready high
// RUN   | substituting group grp_cnt in place, one group per cycle
// DONE  | result held on out_state until out_ready
module inv_subbytes_seq #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);
  localparam int GROUPS = 16 / NUM_SBOX;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] grp_cnt_q, grp_cnt_d;
  logic [0:127]     work_q, work_d;
  logic [7:0]       sbox_in  [NUM_SBOX];
  logic [7:0]       sbox_out [NUM_SBOX];

  // Byte j of the active group feeds S-box j.
  always_comb begin
    for (int j = 0; j < NUM_SBOX; j++) begin
      sbox_in[j] = 8'h00;
      for (int g = 0; g < GROUPS; g++) begin
        if (grp_cnt_q == CNT_W'(g)) sbox_in[j] = work_q[8*(g*NUM_SBOX+j) +: 8];
      end
    end
  end

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
    inv_sbox u_sbox (
      .x (sbox_in[j][7:4]),
      .y (sbox_in[j][3:0]),
      .b (sbox_out[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    grp_cnt_d = grp_cnt_q;
    work_d    = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = in_state;
          grp_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int g = 0; g < GROUPS; g++) begin
          if (grp_cnt_q == CNT_W'(g)) begin
            for (int j = 0; j < NUM_SBOX; j++) work_d[8*(g*NUM_SBOX+j) +: 8] = sbox_out[j];
          end
        end
        if (grp_cnt_q == LAST_GRP) begin
          grp_cnt_d = '0;
          state_d   = DONE;
        end else begin
          grp_cnt_d = grp_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grp_cnt_q <= '0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      grp_cnt_q <= grp_cnt_d;
      work_q    <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_state = work_q;
endmodule
